// File: rtl/regfile_write_arbiter_pkg.sv
// Shared MIPS writeback types: default widths, the zero register and the queued-write entry.
// Types only; no timing or backpressure of its own.
package mips_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  kill;
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback-source, decode-hazard and register-file signals of the write arbiter.
// master drives the ALU/memory streams and read addresses; slave is the arbiter.
interface regfile_write_arbiter_if
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic                     alu_valid;
  logic [ADDR_W-1:0]        alu_rd;
  logic [DATA_W-1:0]        alu_data;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [ADDR_W-1:0]        mem_rd;
  logic [DATA_W-1:0]        mem_data;
  logic [ADDR_W-1:0]        rs;
  logic [ADDR_W-1:0]        rt;
  logic                     rs_busy;
  logic                     rt_busy;
  logic                     alu_stall;
  logic                     RegWrite;
  logic [ADDR_W-1:0]        WriteRd;
  logic [DATA_W-1:0]        WriteData;
  logic [$clog2(DEPTH):0]   queue_count;
  logic                     err_drop;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs, rt,
    input  mem_ready, rs_busy, rt_busy, alu_stall, RegWrite, WriteRd, WriteData,
           queue_count, err_drop
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs, rt,
    output mem_ready, rs_busy, rt_busy, alu_stall, RegWrite, WriteRd, WriteData,
           queue_count, err_drop
  );
endinterface

// File: rtl/regfile_write_arbiter_fifo.sv
// wb_fifo: circular buffer of pending writes with parallel rd compare for kill and busy lookup.
// Push visible at head one cycle later; caller must not push when full nor pop when empty.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             pushEntry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [$clog2(DEPTH):0] count,
  input  logic                  killEn,
  input  logic [DEF_ADDR_W-1:0] killRd,
  input  logic [DEF_ADDR_W-1:0] rsAddr,
  input  logic [DEF_ADDR_W-1:0] rtAddr,
  output logic                  rsMatch,
  output logic                  rtMatch
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t          mem [DEPTH];
  logic [DEPTH-1:0]   occ;
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;

  assign head = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      occ   <= '0;
    end else begin
      if (push) begin
        occ[wrPtr] <= 1'b1;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) begin
        occ[rdPtr] <= 1'b0;
        rdPtr      <= rdPtr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Payload needs no reset: occ alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (killEn) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occ[i] && mem[i].rd == killRd) begin
          mem[i].kill <= 1'b1;
        end
      end
    end
    if (push) begin
      mem[wrPtr] <= pushEntry;
    end
  end

  always_comb begin
    rsMatch = 1'b0;
    rtMatch = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && !mem[i].kill && mem[i].rd == rsAddr) rsMatch = 1'b1;
      if (occ[i] && !mem[i].kill && mem[i].rd == rtAddr) rtMatch = 1'b1;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges the ALU and queued memory writeback streams onto the single register-file write port.
// One-cycle registered write; memory stream backpressured by FIFO fullness, ALU only by alu_stall.
module regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = 8
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  wb_entry_t            pushEntry;
  wb_entry_t            head;
  logic [CNT_W-1:0]     queueCount;
  logic                 fifoEmpty;
  logic                 memReady;
  logic                 aluWins;
  logic                 push;
  logic                 pop;
  logic                 rsMatch;
  logic                 rtMatch;
  logic [STARVE_W-1:0]  starveCnt;
  logic [STARVE_W-1:0]  starveNext;
  logic                 aluStallQ;
  logic                 errDropQ;
  logic                 regWriteQ;
  logic [ADDR_W-1:0]    writeRdQ;
  logic [DATA_W-1:0]    writeDataQ;

  assign fifoEmpty = (queueCount == '0);
  assign memReady  = (queueCount < FULL_COUNT);
  assign aluWins   = bus.alu_valid && !aluStallQ && (bus.alu_rd != REG_ZERO);
  assign pop       = !fifoEmpty && !aluWins;
  // Writes to $zero are accepted from the producer but never queued.
  assign push      = bus.mem_valid && memReady && (bus.mem_rd != REG_ZERO);

  always_comb begin
    pushEntry      = '0;
    pushEntry.kill = 1'b0;
    pushEntry.rd   = bus.mem_rd;
    pushEntry.data = bus.mem_data;
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .head      (head),
    .count     (queueCount),
    .killEn    (aluWins),
    .killRd    (bus.alu_rd),
    .rsAddr    (bus.rs),
    .rtAddr    (bus.rt),
    .rsMatch   (rsMatch),
    .rtMatch   (rtMatch)
  );

  // While the FIFO is waiting, only a winning ALU write can leave it non-empty without a pop.
  assign starveNext = (fifoEmpty || pop) ? '0 : starveCnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      regWriteQ  <= 1'b0;
      writeRdQ   <= '0;
      writeDataQ <= '0;
      starveCnt  <= '0;
      aluStallQ  <= 1'b0;
      errDropQ   <= 1'b0;
    end else begin
      if (bus.alu_valid && aluStallQ) begin
        errDropQ <= 1'b1;
      end
      if (aluWins) begin
        regWriteQ  <= 1'b1;
        writeRdQ   <= bus.alu_rd;
        writeDataQ <= bus.alu_data;
      end else if (pop) begin
        regWriteQ <= !head.kill;
        if (!head.kill) begin
          writeRdQ   <= head.rd;
          writeDataQ <= head.data;
        end
      end else begin
        regWriteQ <= 1'b0;
      end
      starveCnt <= starveNext;
      aluStallQ <= (starveNext == STARVE_MAX);
    end
  end

  assign bus.mem_ready   = memReady;
  assign bus.rs_busy     = (bus.rs != REG_ZERO) && rsMatch;
  assign bus.rt_busy     = (bus.rt != REG_ZERO) && rtMatch;
  assign bus.alu_stall   = aluStallQ;
  assign bus.RegWrite    = regWriteQ;
  assign bus.WriteRd     = writeRdQ;
  assign bus.WriteData   = writeDataQ;
  assign bus.queue_count = queueCount;
  assign bus.err_drop    = errDropQ;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized bench for regfile_write_arbiter against a queue-based reference model.
// Inputs change and outputs are sampled around the falling edge.
module tb_regfile_write_arbiter;
  import mips_pkg::*;

  localparam int DEPTH        = 4;
  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int STARVE_LIMIT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          kill;
    logic [4:0]  rd;
    logic [31:0] data;
  } ref_t;

  ref_t        q[$];
  bit          mRegWrite;
  logic [4:0]  mWriteRd;
  logic [31:0] mWriteData;
  bit          mStall;
  bit          mErr;
  int          mStarve;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stallSeen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit busyOf(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q[i]) if (!q[i].kill && q[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    q.delete();
    mRegWrite  = 1'b0;
    mWriteRd   = '0;
    mWriteData = '0;
    mStall     = 1'b0;
    mErr       = 1'b0;
    mStarve    = 0;
  endtask

  task automatic modelAdvance();
    ref_t e;
    bit   aluIssue;
    bit   popped;
    int   sizeBefore;
    if (reset) begin
      modelReset();
      return;
    end
    sizeBefore = q.size();
    aluIssue   = bus.alu_valid && !mStall && bus.alu_rd != 5'd0;
    if (bus.alu_valid && mStall) mErr = 1'b1;
    popped = 1'b0;
    if (aluIssue) begin
      foreach (q[i]) if (q[i].rd == bus.alu_rd) q[i].kill = 1'b1;
      mRegWrite  = 1'b1;
      mWriteRd   = bus.alu_rd;
      mWriteData = bus.alu_data;
    end else if (sizeBefore > 0) begin
      e = q.pop_front();
      popped = 1'b1;
      mRegWrite = !e.kill;
      if (!e.kill) begin
        mWriteRd   = e.rd;
        mWriteData = e.data;
      end
    end else begin
      mRegWrite = 1'b0;
    end
    if (sizeBefore == 0 || popped) mStarve = 0;
    else mStarve++;
    mStall = (mStarve == STARVE_LIMIT);
    if (bus.mem_valid && sizeBefore < DEPTH && bus.mem_rd != 5'd0) begin
      e.kill = 1'b0;
      e.rd   = bus.mem_rd;
      e.data = bus.mem_data;
      q.push_back(e);
    end
  endtask

  // Check every output against the model, advance the model, move to the next falling edge.
  task automatic step();
    #1;
    chk($sformatf("c%0d RegWrite", cyc),    32'(bus.RegWrite),    32'(mRegWrite));
    chk($sformatf("c%0d WriteRd", cyc),     32'(bus.WriteRd),     32'(mWriteRd));
    chk($sformatf("c%0d WriteData", cyc),   bus.WriteData,        mWriteData);
    chk($sformatf("c%0d queue_count", cyc), 32'(bus.queue_count), 32'(q.size()));
    chk($sformatf("c%0d mem_ready", cyc),   32'(bus.mem_ready),   32'(q.size() < DEPTH));
    chk($sformatf("c%0d alu_stall", cyc),   32'(bus.alu_stall),   32'(mStall));
    chk($sformatf("c%0d err_drop", cyc),    32'(bus.err_drop),    32'(mErr));
    chk($sformatf("c%0d rs_busy", cyc),     32'(bus.rs_busy),     32'(busyOf(bus.rs)));
    chk($sformatf("c%0d rt_busy", cyc),     32'(bus.rt_busy),     32'(busyOf(bus.rt)));
    modelAdvance();
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
    bus.rs        = '0;
    bus.rt        = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    modelReset();
    step();
    reset = 1'b0;

    // 1: single ALU write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hA5;
    step();
    idle();
    #1 chk("t1_RegWrite", 32'(bus.RegWrite), 32'd1);
    chk("t1_WriteRd", 32'(bus.WriteRd), 32'd5);
    chk("t1_WriteData", bus.WriteData, 32'hA5);
    step();
    step();

    // 2: fill the FIFO behind ALU traffic, then drain in order
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'(i);
      bus.mem_valid = 1'b1; bus.mem_rd = 5'(8 + i); bus.mem_data = 32'(100 + i);
      step();
    end
    idle();
    #1 chk("t2_full_ready", 32'(bus.mem_ready), 32'd0);
    chk("t2_full_count", 32'(bus.queue_count), 32'd4);
    for (int i = 0; i < 6; i++) step();
    #1 chk("t2_drained", 32'(bus.queue_count), 32'd0);

    // 3: starvation forces the queued write through
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'd1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h300;
    step();
    stallSeen = 0;
    for (int i = 0; i < 12; i++) begin
      idle();
      bus.alu_valid = !mStall; bus.alu_rd = 5'd3; bus.alu_data = 32'(32'h301 + i);
      #1 stallSeen += int'(bus.alu_stall);
      step();
    end
    chk("t3_stall_cycles", 32'(stallSeen), 32'd1);
    idle();
    step(); step();

    // 4: younger ALU write kills the queued write to the same register
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'd1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
    step();
    idle();
    bus.rs = 5'd9;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'd2;
    #1 chk("t4_busy_before", 32'(bus.rs_busy), 32'd1);
    step();
    idle();
    bus.rs = 5'd9;
    #1 chk("t4_busy_after", 32'(bus.rs_busy), 32'd0);
    chk("t4_alu_won", bus.WriteData, 32'd2);
    for (int i = 0; i < 3; i++) step();

    // 5: writes to $zero from both streams
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hDEAD;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hBEEF;
      step();
    end
    idle();
    step();
    #1 chk("t5_count", 32'(bus.queue_count), 32'd0);

    // 6: reset with a partly full FIFO, then an ALU write during a forced stall
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'(i);
      bus.mem_valid = 1'b1; bus.mem_rd = 5'(12 + i); bus.mem_data = 32'(200 + i);
      step();
    end
    idle();
    #1 chk("t6_prefill", 32'(bus.queue_count), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 chk("t6_rst_count", 32'(bus.queue_count), 32'd0);
    chk("t6_rst_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("t6_rst_WriteRd", 32'(bus.WriteRd), 32'd0);
    chk("t6_rst_WriteData", bus.WriteData, 32'd0);
    for (int i = 0; i < 3; i++) step();
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd15; bus.mem_data = 32'd15;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h22;
    step();
    for (int i = 0; i < 12; i++) begin
      idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'(i);
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) step();
    #1 chk("t6_err_sticky", 32'(bus.err_drop), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 chk("t6_err_cleared", 32'(bus.err_drop), 32'd0);

    // Randomized traffic with a well-behaved ALU producer and occasional reset
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 99) == 0);
      bus.alu_valid = ($urandom_range(0, 99) < 55) && !mStall;
      bus.alu_rd    = 5'($urandom_range(0, 7));
      bus.alu_data  = $urandom();
      bus.mem_valid = ($urandom_range(0, 99) < 45);
      bus.mem_rd    = 5'($urandom_range(0, 7));
      bus.mem_data  = $urandom();
      bus.rs        = 5'($urandom_range(0, 7));
      bus.rt        = 5'($urandom_range(0, 7));
      step();
    end
    reset = 1'b0;
    idle();
    for (int i = 0; i < 6; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
